pixel_fetch_responder: RTL and testbench

Serves coordinate-addressed pixel requests from the motion-prediction engine. Each accepted `(x, y)` request produces one RGB pixel and its background statistics (mean gray, variance) for that location. The block fetches three 16-bit words from the shared frame SRAM through a request/grant/rvalid port and returns them as a single valid pulse. It sits between the motion predictor's coordinate port and the SRAM arbiter it shares with the VGA scanout path.

---
 rtl/pixel_fetch_responder.sv | 228 ++++++++++++++++++++++
 tb/tb_pixel_fetch_responder.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_fetch_responder.sv
// Coordinate-addressed pixel fetch: turns one (x, y) request into three SRAM word reads
// (pix0, pix1, stats) and returns RGB plus background mean/variance as a single valid pulse.
module pixel_fetch_responder #(
    parameter int          WIDTH     = 640,
    parameter int          HEIGHT    = 480,
    parameter logic [19:0] PIX_BASE  = 20'h00000,
    parameter logic [19:0] STAT_BASE = 20'h96000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_coord_valid,
    input  logic [10:0] i_x,
    input  logic [10:0] i_y,
    output logic        o_valid,
    output logic [7:0]  o_r,
    output logic [7:0]  o_g,
    output logic [7:0]  o_b,
    output logic [7:0]  o_pix_x,
    output logic [7:0]  o_pix_x2,
    output logic        o_err,
    output logic        o_busy,
    output logic        o_drop,
    output logic        o_mem_req,
    output logic [19:0] o_mem_addr,
    input  logic        i_mem_gnt,
    input  logic        i_mem_rvalid,
    input  logic [15:0] i_mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        RD0,
        W0,
        RD1,
        W1,
        RD2,
        W2,
        RESP
    } state_t;

    localparam logic [19:0] WIDTH20    = 20'(WIDTH);
    localparam logic [11:0] WIDTH_LIM  = 12'(WIDTH);
    localparam logic [11:0] HEIGHT_LIM = 12'(HEIGHT);

    state_t      state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic [19:0] mem_addr_q, mem_addr_d;
    logic [19:0] pix1_q, pix1_d;
    logic [19:0] stat_q, stat_d;
    logic [7:0]  stg_r_q, stg_r_d;
    logic [7:0]  stg_g_q, stg_g_d;
    logic [7:0]  stg_b_q, stg_b_d;
    logic [7:0]  r_q, r_d;
    logic [7:0]  g_q, g_d;
    logic [7:0]  b_q, b_d;
    logic [7:0]  mean_q, mean_d;
    logic [7:0]  var_q, var_d;
    logic        err_q, err_d;
    logic        valid_q, valid_d;

    logic [19:0] x20;
    logic [19:0] y20;
    logic [19:0] idx;
    logic [19:0] pix0_addr;
    logic [19:0] stat_addr;
    logic        in_range;

    // Linear index; the 640-wide case uses shift-add so no multiplier is built.
    always_comb begin
        x20 = {9'd0, i_x};
        y20 = {9'd0, i_y};
        if (WIDTH == 640) begin
            idx = (y20 << 9) + (y20 << 7) + x20;
        end else begin
            idx = (y20 * WIDTH20) + x20;
        end
        pix0_addr = PIX_BASE + (idx << 1);
        stat_addr = STAT_BASE + idx;
        in_range  = ({1'b0, i_x} < WIDTH_LIM) && ({1'b0, i_y} < HEIGHT_LIM);
    end

    // NOTE: every signal gets a hold-value default first so no branch can leave one unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        pix1_d     = pix1_q;
        stat_d     = stat_q;
        stg_r_d    = stg_r_q;
        stg_g_d    = stg_g_q;
        stg_b_d    = stg_b_q;
        r_d        = r_q;
        g_d        = g_q;
        b_d        = b_q;
        mean_d     = mean_q;
        var_d      = var_q;
        err_d      = err_q;
        valid_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_coord_valid) begin
                    if (in_range) begin
                        state_d    = RD0;
                        mem_req_d  = 1'b1;
                        mem_addr_d = pix0_addr;
                        pix1_d     = pix0_addr + 20'd1;
                        stat_d     = stat_addr;
                    end else begin
                        state_d = RESP;
                        valid_d = 1'b1;
                        err_d   = 1'b1;
                        r_d     = 8'd0;
                        g_d     = 8'd0;
                        b_d     = 8'd0;
                        mean_d  = 8'd0;
                        var_d   = 8'd0;
                    end
                end
            end
            RD0: begin
                if (i_mem_gnt) begin
                    state_d   = W0;
                    mem_req_d = 1'b0;
                end
            end
            W0: begin
                if (i_mem_rvalid) begin
                    stg_r_d    = i_mem_rdata[15:8];
                    stg_g_d    = i_mem_rdata[7:0];
                    state_d    = RD1;
                    mem_req_d  = 1'b1;
                    mem_addr_d = pix1_q;
                end
            end
            RD1: begin
                if (i_mem_gnt) begin
                    state_d   = W1;
                    mem_req_d = 1'b0;
                end
            end
            W1: begin
                if (i_mem_rvalid) begin
                    stg_b_d    = i_mem_rdata[15:8];
                    state_d    = RD2;
                    mem_req_d  = 1'b1;
                    mem_addr_d = stat_q;
                end
            end
            RD2: begin
                if (i_mem_gnt) begin
                    state_d   = W2;
                    mem_req_d = 1'b0;
                end
            end
            W2: begin
                // Outputs update only on entry to RESP so they hold steady between responses.
                if (i_mem_rvalid) begin
                    state_d = RESP;
                    valid_d = 1'b1;
                    err_d   = 1'b0;
                    r_d     = stg_r_q;
                    g_d     = stg_g_q;
                    b_d     = stg_b_q;
                    mean_d  = i_mem_rdata[15:8];
                    var_d   = i_mem_rdata[7:0];
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= 20'd0;
            pix1_q     <= 20'd0;
            stat_q     <= 20'd0;
            stg_r_q    <= 8'd0;
            stg_g_q    <= 8'd0;
            stg_b_q    <= 8'd0;
            r_q        <= 8'd0;
            g_q        <= 8'd0;
            b_q        <= 8'd0;
            mean_q     <= 8'd0;
            var_q      <= 8'd0;
            err_q      <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            pix1_q     <= pix1_d;
            stat_q     <= stat_d;
            stg_r_q    <= stg_r_d;
            stg_g_q    <= stg_g_d;
            stg_b_q    <= stg_b_d;
            r_q        <= r_d;
            g_q        <= g_d;
            b_q        <= b_d;
            mean_q     <= mean_d;
            var_q      <= var_d;
            err_q      <= err_d;
            valid_q    <= valid_d;
        end
    end

    assign o_valid    = valid_q;
    assign o_r        = r_q;
    assign o_g        = g_q;
    assign o_b        = b_q;
    assign o_pix_x    = mean_q;
    assign o_pix_x2   = var_q;
    assign o_err      = err_q;
    assign o_busy     = (state_q != IDLE);
    assign o_drop     = i_coord_valid && (state_q != IDLE);
    assign o_mem_req  = mem_req_q;
    assign o_mem_addr = mem_addr_q;

endmodule

// File: tb/tb_pixel_fetch_responder.sv
// Scoreboard bench for pixel_fetch_responder: an SRAM model checks read addresses,
// and a monitor compares each response with the value queued when the request was sent.
module tb_pixel_fetch_responder;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_coord_valid;
    logic [10:0] i_x;
    logic [10:0] i_y;
    logic        o_valid;
    logic [7:0]  o_r;
    logic [7:0]  o_g;
    logic [7:0]  o_b;
    logic [7:0]  o_pix_x;
    logic [7:0]  o_pix_x2;
    logic        o_err;
    logic        o_busy;
    logic        o_drop;
    logic        o_mem_req;
    logic [19:0] o_mem_addr;
    logic        i_mem_gnt;
    logic        i_mem_rvalid;
    logic [15:0] i_mem_rdata;

    pixel_fetch_responder dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_coord_valid (i_coord_valid),
        .i_x           (i_x),
        .i_y           (i_y),
        .o_valid       (o_valid),
        .o_r           (o_r),
        .o_g           (o_g),
        .o_b           (o_b),
        .o_pix_x       (o_pix_x),
        .o_pix_x2      (o_pix_x2),
        .o_err         (o_err),
        .o_busy        (o_busy),
        .o_drop        (o_drop),
        .o_mem_req     (o_mem_req),
        .o_mem_addr    (o_mem_addr),
        .i_mem_gnt     (i_mem_gnt),
        .i_mem_rvalid  (i_mem_rvalid),
        .i_mem_rdata   (i_mem_rdata)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic [7:0] px;
        logic [7:0] px2;
        logic       err;
        int         cyc;
    } resp_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    resp_t       resp_q[$];
    logic [19:0] addr_q[$];
    logic [15:0] mem[int];

    // SRAM model controls
    bit          pend = 1'b0;
    logic [19:0] pend_addr = 20'd0;
    int          req_cycles = 0;
    logic [19:0] stall_addr = 20'd0;
    int          stall_left = 0;
    bit          stall_active = 1'b0;
    logic [19:0] stall_hold = 20'd0;
    bit          stray_rv = 1'b0;
    logic [19:0] exp_addr;
    resp_t       mon_e;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] rd_word(input logic [19:0] a);
        if (mem.exists(int'(a))) return mem[int'(a)];
        return 16'h0000;
    endfunction

    always @(posedge i_clk) cyc <= cyc + 1;

    // SRAM / arbiter model: grant in the same cycle as a request, rvalid the cycle after.
    always @(negedge i_clk) begin
        if (!i_rst_n) begin
            i_mem_gnt    = 1'b0;
            i_mem_rvalid = 1'b0;
            i_mem_rdata  = 16'h0000;
            pend         = 1'b0;
            stall_active = 1'b0;
        end else begin
            if (pend) begin
                i_mem_rvalid = 1'b1;
                i_mem_rdata  = rd_word(pend_addr);
            end else if (stray_rv) begin
                i_mem_rvalid = 1'b1;
                i_mem_rdata  = 16'hBEEF;
            end else begin
                i_mem_rvalid = 1'b0;
                i_mem_rdata  = 16'h0000;
            end
            pend      = 1'b0;
            i_mem_gnt = 1'b0;
            if (stall_active) begin
                check("stall_req_held", 32'(o_mem_req), 1);
                check("stall_addr_stable", 32'(o_mem_addr), 32'(stall_hold));
            end
            if (o_mem_req) begin
                req_cycles++;
                if (stall_left > 0 && (stall_active || o_mem_addr == stall_addr)) begin
                    stall_active = 1'b1;
                    stall_hold   = o_mem_addr;
                    stall_left--;
                end else begin
                    stall_active = 1'b0;
                    i_mem_gnt    = 1'b1;
                    pend         = 1'b1;
                    pend_addr    = o_mem_addr;
                    if (addr_q.size() == 0) begin
                        check("unexpected_mem_req", 32'(o_mem_req), 0);
                    end else begin
                        exp_addr = addr_q.pop_front();
                        check("mem_addr", 32'(o_mem_addr), 32'(exp_addr));
                    end
                end
            end else begin
                stall_active = 1'b0;
            end
        end
    end

    // Response monitor
    always @(negedge i_clk) begin
        if (i_rst_n && o_valid) begin
            if (resp_q.size() == 0) begin
                check("unexpected_valid", 32'(o_valid), 0);
            end else begin
                mon_e = resp_q.pop_front();
                check("resp_r", 32'(o_r), 32'(mon_e.r));
                check("resp_g", 32'(o_g), 32'(mon_e.g));
                check("resp_b", 32'(o_b), 32'(mon_e.b));
                check("resp_mean", 32'(o_pix_x), 32'(mon_e.px));
                check("resp_var", 32'(o_pix_x2), 32'(mon_e.px2));
                check("resp_err", 32'(o_err), 32'(mon_e.err));
                check("resp_latency", cyc, mon_e.cyc);
            end
        end
    end

    task automatic send(input int x, input int y, input logic [15:0] w0, input logic [15:0] w1,
                        input logic [15:0] w2, input int lat, input bit abort);
        int    idx;
        resp_t e;
        if (x < 640 && y < 480) begin
            idx = y * 640 + x;
            mem[2 * idx]           = w0;
            mem[2 * idx + 1]       = w1;
            mem[32'h96000 + idx]   = w2;
            addr_q.push_back(20'(2 * idx));
            addr_q.push_back(20'(2 * idx + 1));
            if (!abort) addr_q.push_back(20'(32'h96000 + idx));
            e.r   = w0[15:8];
            e.g   = w0[7:0];
            e.b   = w1[15:8];
            e.px  = w2[15:8];
            e.px2 = w2[7:0];
            e.err = 1'b0;
        end else begin
            e.r   = 8'd0;
            e.g   = 8'd0;
            e.b   = 8'd0;
            e.px  = 8'd0;
            e.px2 = 8'd0;
            e.err = 1'b1;
        end
        @(negedge i_clk);
        i_coord_valid = 1'b1;
        i_x           = 11'(x);
        i_y           = 11'(y);
        e.cyc         = cyc + lat;
        if (!abort) resp_q.push_back(e);
        @(negedge i_clk);
        i_coord_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (resp_q.size() != 0 && n < 100) begin
            @(negedge i_clk);
            n++;
        end
        check("done_timeout", resp_q.size(), 0);
        resp_q.delete();
        @(negedge i_clk);
    endtask

    int req_snap;

    initial begin
        i_rst_n       = 1'b0;
        i_coord_valid = 1'b0;
        i_x           = 11'd0;
        i_y           = 11'd0;
        i_mem_gnt     = 1'b0;
        i_mem_rvalid  = 1'b0;
        i_mem_rdata   = 16'h0000;
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check("rst_valid", 32'(o_valid), 0);
        check("rst_rgb", {8'd0, o_r, o_g, o_b}, 0);
        check("rst_stats", {16'd0, o_pix_x, o_pix_x2}, 0);
        check("rst_flags", {28'd0, o_err, o_busy, o_drop, o_mem_req}, 0);
        check("rst_mem_addr", 32'(o_mem_addr), 0);

        // Basic in-range request, then response holds while idle
        send(3, 2, 16'hA1B2, 16'hC3FF, 16'h4D05, 7, 1'b0);
        wait_done();
        repeat (3) @(negedge i_clk);
        check("hold_r", 32'(o_r), 32'h A1);
        check("hold_b", 32'(o_b), 32'h C3);
        check("hold_var", 32'(o_pix_x2), 32'h05);
        check("hold_valid_low", 32'(o_valid), 0);
        check("idle_busy", 32'(o_busy), 0);

        // Last pixel, with stray rvalid pulses outside the wait states
        stray_rv = 1'b1;
        send(639, 479, 16'h1234, 16'h5678, 16'h9ABC, 7, 1'b0);
        wait_done();
        stray_rv = 1'b0;
        @(negedge i_clk);

        // Out-of-range coordinates: no memory traffic, immediate error response
        req_snap = req_cycles;
        send(640, 0, 16'h0, 16'h0, 16'h0, 1, 1'b0);
        wait_done();
        send(0, 480, 16'h0, 16'h0, 16'h0, 1, 1'b0);
        wait_done();
        send(2047, 2047, 16'h0, 16'h0, 16'h0, 1, 1'b0);
        wait_done();
        check("oor_no_mem_req", req_cycles, req_snap);

        // Grant withheld for 5 cycles in RD1
        stall_addr = 20'(2 * (20 * 640 + 10) + 1);
        stall_left = 5;
        send(10, 20, 16'h0F1E, 16'h2D00, 16'h3C4B, 12, 1'b0);
        wait_done();
        check("stall_consumed", stall_left, 0);

        // Request while busy in W0 is dropped
        send(100, 50, 16'h5566, 16'h7788, 16'h99AA, 7, 1'b0);
        @(negedge i_clk);
        i_coord_valid = 1'b1;
        i_x           = 11'd700;
        i_y           = 11'd5;
        #1 check("drop_pulse", 32'(o_drop), 1);
        check("drop_busy", 32'(o_busy), 1);
        @(negedge i_clk);
        i_coord_valid = 1'b0;
        #1 check("drop_clear", 32'(o_drop), 0);
        wait_done();

        // Reset asserted in W1 aborts the request without a response
        send(5, 5, 16'hDEAD, 16'hBEEF, 16'hCAFE, 7, 1'b1);
        repeat (3) @(negedge i_clk);
        #2 i_rst_n = 1'b0;
        #1 check("abort_busy", 32'(o_busy), 0);
        check("abort_mem_req", 32'(o_mem_req), 0);
        check("abort_valid", 32'(o_valid), 0);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (2) @(negedge i_clk);
        check("abort_addr_q", addr_q.size(), 0);
        send(7, 9, 16'h1357, 16'h9B00, 16'h2468, 7, 1'b0);
        wait_done();

        repeat (3) @(negedge i_clk);
        check("final_addr_q", addr_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
